// File: rtl/mac_accumulator.sv
// mac_accumulator: sums a programmable-length frame of signed products from
// the Booth multiplier and hands one dot-product result to the consumer.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; the last result is held on out_acc/out_ovf
//   S_ACCUM | in_ready high, adding one product per accepted beat
//   S_DONE  | out_valid high, result held until out_ready
module mac_accumulator #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  logic [ACC_W-1:0]  out_acc_q;
  logic              out_ovf_q;

  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  sum;
  logic              add_ovf;
  logic              beat;
  logic              last_beat;

  // Replication count is always >= 1, so this also works when ACC_W == PROD_W.
  assign prod_ext  = {{(ACC_W-PROD_W+1){in_prod[PROD_W-1]}}, in_prod[PROD_W-2:0]};
  assign sum       = acc + prod_ext;
  assign add_ovf   = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  assign beat      = (state == S_ACCUM) && in_valid;
  assign last_beat = beat && (cnt == CNT_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (len == '0) ? S_DONE : S_ACCUM;
      end
      S_ACCUM: begin
        if (last_beat) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Accumulator, down-counter and result registers; the result registers
  // only load on entry to S_DONE so they stay stable through the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_acc_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt <= len;
            acc <= '0;
            ovf <= 1'b0;
            if (len == '0) begin
              out_acc_q <= '0;
              out_ovf_q <= 1'b0;
            end
          end
        end
        S_ACCUM: begin
          if (beat) begin
            acc <= sum;
            cnt <= cnt - CNT_W'(1);
            ovf <= ovf | add_ovf;
            if (last_beat) begin
              out_acc_q <= sum;
              out_ovf_q <= ovf | add_ovf;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_ACCUM);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign out_acc   = out_acc_q;
  assign out_ovf   = out_ovf_q;

endmodule
